ads_spi_mux_axil_regs: RTL and testbench

AXI4-Lite slave register file for the ADS SPI multiplexer. It answers AXI4-Lite single-beat reads and writes from the PS or a VIP master, and holds four 32-bit read/write control registers. Each register drives the mux datapath directly, and a one-cycle pulse marks every committed write. It sits between the AXI interconnect and the mux core, on the responder side of the S00_AXI bus.

---
 rtl/ads_spi_mux_axil_regs_if.sv | 51 +++++
 rtl/ads_spi_mux_axil_regs.sv | 135 +++++++++++++
 tb/tb_ads_spi_mux_axil_regs.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ads_spi_mux_axil_regs_if.sv
// AXI4-Lite bus bundle between the interconnect and the ADS SPI mux register file.
interface ads_spi_mux_axil_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/ads_spi_mux_axil_regs.sv
// AXI4-Lite slave holding the four control words of the ADS SPI mux.
// AW and W are accepted independently; the write commits on the edge where
// both are available, and a one-cycle pulse flags the register written.
module ads_spi_mux_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  ads_spi_mux_axil_regs_if.slave        s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg3,
  output logic [3:0]                    reg_wr_pulse
);
  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int IDX_HI = C_S_AXI_ADDR_WIDTH - 1;

  // Byte-lane merge: lanes with strobe low keep their previous contents.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0]     old_word,
                                                input logic [DW-1:0]     new_word,
                                                input logic [STRB_W-1:0] strb);
    logic [DW-1:0] res;
    res = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  logic [DW-1:0]     regs [4];

  logic              aw_held;
  logic              w_held;
  logic [1:0]        aw_idx;
  logic [DW-1:0]     w_data;
  logic [STRB_W-1:0] w_strb;
  logic              awready;
  logic              wready;
  logic              bvalid;

  logic              arready;
  logic              rvalid;
  logic [DW-1:0]     rdata;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [1:0]        cm_idx;
  logic [DW-1:0]     cm_data;
  logic [STRB_W-1:0] cm_strb;
  logic              aw_held_n;
  logic              w_held_n;
  logic              bvalid_n;
  logic              rvalid_n;
  logic              unused_bits;

  assign aw_hs  = s_axi.S_AXI_AWVALID && awready;
  assign w_hs   = s_axi.S_AXI_WVALID && wready;
  assign ar_hs  = s_axi.S_AXI_ARVALID && arready;

  // A commit needs both halves, either already held or arriving this edge.
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign cm_idx  = aw_held ? aw_idx : s_axi.S_AXI_AWADDR[IDX_HI -: 2];
  assign cm_data = w_held ? w_data : s_axi.S_AXI_WDATA;
  assign cm_strb = w_held ? w_strb : s_axi.S_AXI_WSTRB;

  assign aw_held_n = commit ? 1'b0 : (aw_held || aw_hs);
  assign w_held_n  = commit ? 1'b0 : (w_held || w_hs);
  assign bvalid_n  = commit ? 1'b1 : (bvalid && !s_axi.S_AXI_BREADY);
  assign rvalid_n  = ar_hs ? 1'b1 : (rvalid && !s_axi.S_AXI_RREADY);

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[IDX_HI-2:0], s_axi.S_AXI_ARADDR[IDX_HI-2:0]};

  // Write path: capture AW/W halves, commit the merged word, raise response and pulse.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      awready      <= 1'b0;
      wready       <= 1'b0;
      bvalid       <= 1'b0;
      reg_wr_pulse <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      aw_held      <= aw_held_n;
      w_held       <= w_held_n;
      bvalid       <= bvalid_n;
      awready      <= !aw_held_n && !bvalid_n;
      wready       <= !w_held_n && !bvalid_n;
      reg_wr_pulse <= commit ? (4'b0001 << cm_idx) : 4'b0000;
      if (aw_hs) aw_idx <= s_axi.S_AXI_AWADDR[IDX_HI -: 2];
      if (w_hs) begin
        w_data <= s_axi.S_AXI_WDATA;
        w_strb <= s_axi.S_AXI_WSTRB;
      end
      if (commit) regs[cm_idx] <= merge_bytes(regs[cm_idx], cm_data, cm_strb);
    end
  end

  // Read path: load the addressed word on AR handshake; a same-edge write is not yet visible.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rvalid  <= 1'b0;
      arready <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid  <= rvalid_n;
      arready <= !rvalid_n;
      if (ar_hs) rdata <= regs[s_axi.S_AXI_ARADDR[IDX_HI -: 2]];
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign slv_reg0 = regs[0];
  assign slv_reg1 = regs[1];
  assign slv_reg2 = regs[2];
  assign slv_reg3 = regs[3];
endmodule

// File: tb/tb_ads_spi_mux_axil_regs.sv
// Bench for the ADS SPI mux AXI4-Lite register file: directed transactions,
// a queue-based transaction model checked every cycle, and literal expectations.
module tb_ads_spi_mux_axil_regs;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic [3:0]  reg_wr_pulse;

  int errors = 0;
  int checks = 0;

  ads_spi_mux_axil_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  ads_spi_mux_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axi        (bus),
    .slv_reg0     (slv_reg0),
    .slv_reg1     (slv_reg1),
    .slv_reg2     (slv_reg2),
    .slv_reg3     (slv_reg3),
    .reg_wr_pulse (reg_wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] mdl_reg [4] = '{default: 32'h0};
  int          aw_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];
  logic [31:0] rd_q [$];
  logic        exp_bvalid = 1'b0;
  logic        exp_awr    = 1'b0;
  logic        exp_wr     = 1'b0;
  logic        exp_arr    = 1'b0;
  logic [3:0]  exp_pulse  = 4'h0;

  // Compare on the falling edge, then predict what the coming rising edge does.
  always @(negedge clk) begin
    logic        aw_go, w_go, ar_go;
    logic [31:0] rv, d;
    logic [3:0]  s;
    int          k;
    if (rst) begin
      for (int i = 0; i < 4; i++) mdl_reg[i] = 32'h0;
      aw_q.delete(); wd_q.delete(); ws_q.delete(); rd_q.delete();
      exp_bvalid = 1'b0; exp_awr = 1'b0; exp_wr = 1'b0; exp_arr = 1'b0;
      exp_pulse  = 4'h0;
    end
    chk("m_slv_reg0", slv_reg0, mdl_reg[0]);
    chk("m_slv_reg1", slv_reg1, mdl_reg[1]);
    chk("m_slv_reg2", slv_reg2, mdl_reg[2]);
    chk("m_slv_reg3", slv_reg3, mdl_reg[3]);
    chk("m_pulse",   {28'h0, reg_wr_pulse}, {28'h0, exp_pulse});
    chk("m_bvalid",  {31'h0, bus.S_AXI_BVALID}, {31'h0, exp_bvalid});
    chk("m_rvalid",  {31'h0, bus.S_AXI_RVALID}, {31'h0, rd_q.size() != 0});
    chk("m_awready", {31'h0, bus.S_AXI_AWREADY}, {31'h0, exp_awr});
    chk("m_wready",  {31'h0, bus.S_AXI_WREADY}, {31'h0, exp_wr});
    chk("m_arready", {31'h0, bus.S_AXI_ARREADY}, {31'h0, exp_arr});
    chk("m_bresp",   {30'h0, bus.S_AXI_BRESP}, 32'h0);
    chk("m_rresp",   {30'h0, bus.S_AXI_RRESP}, 32'h0);
    if (rd_q.size() != 0) chk("m_rdata", bus.S_AXI_RDATA, rd_q[0]);
    if (!rst) begin
      aw_go = bus.S_AXI_AWVALID && exp_awr;
      w_go  = bus.S_AXI_WVALID && exp_wr;
      ar_go = bus.S_AXI_ARVALID && exp_arr;
      rv    = 32'h0;
      if (aw_go) aw_q.push_back(int'(bus.S_AXI_AWADDR) / 4);
      if (w_go) begin
        wd_q.push_back(bus.S_AXI_WDATA);
        ws_q.push_back(bus.S_AXI_WSTRB);
      end
      if (ar_go) rv = mdl_reg[int'(bus.S_AXI_ARADDR) / 4];
      if (exp_bvalid && bus.S_AXI_BREADY) exp_bvalid = 1'b0;
      if (rd_q.size() != 0 && bus.S_AXI_RREADY) void'(rd_q.pop_front());
      if (ar_go) rd_q.push_back(rv);
      exp_pulse = 4'h0;
      if (aw_q.size() != 0 && wd_q.size() != 0) begin
        k = aw_q.pop_front();
        d = wd_q.pop_front();
        s = ws_q.pop_front();
        for (int b = 0; b < 4; b++)
          if (s[b]) mdl_reg[k][8*b +: 8] = d[8*b +: 8];
        exp_bvalid   = 1'b1;
        exp_pulse[k] = 1'b1;
      end
      exp_awr = (aw_q.size() == 0) && !exp_bvalid;
      exp_wr  = (wd_q.size() == 0) && !exp_bvalid;
      exp_arr = (rd_q.size() == 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_go, w_go;
    int n = 0;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_WVALID  = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge clk);
      aw_go = !aw_done && bus.S_AXI_AWREADY;
      w_go  = !w_done && bus.S_AXI_WREADY;
      @(posedge clk); #1;
      if (aw_go) begin aw_done = 1'b1; bus.S_AXI_AWVALID = 1'b0; end
      if (w_go)  begin w_done  = 1'b1; bus.S_AXI_WVALID  = 1'b0; end
      n++;
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    chk("wr_handshake", {30'h0, aw_done, w_done}, 32'h3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.S_AXI_BVALID && n < 20);
    chk("wr_bvalid", {31'h0, bus.S_AXI_BVALID}, 32'h1);
    chk("wr_bresp", {30'h0, bus.S_AXI_BRESP}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    bit ar_done = 1'b0;
    bit ar_go;
    int n = 0;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    while (!ar_done && n < 20) begin
      @(negedge clk);
      ar_go = bus.S_AXI_ARREADY;
      @(posedge clk); #1;
      if (ar_go) begin ar_done = 1'b1; bus.S_AXI_ARVALID = 1'b0; end
      n++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    chk("rd_handshake", {31'h0, ar_done}, 32'h1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.S_AXI_RVALID && n < 20);
    chk("rd_rvalid", {31'h0, bus.S_AXI_RVALID}, 32'h1);
    chk("rd_rresp", {30'h0, bus.S_AXI_RRESP}, 32'h0);
    data = bus.S_AXI_RDATA;
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, {31'h0, bus.S_AXI_AWREADY}, 32'h0);
    chk({tag, "_wready"},  {31'h0, bus.S_AXI_WREADY}, 32'h0);
    chk({tag, "_arready"}, {31'h0, bus.S_AXI_ARREADY}, 32'h0);
    chk({tag, "_bvalid"},  {31'h0, bus.S_AXI_BVALID}, 32'h0);
    chk({tag, "_rvalid"},  {31'h0, bus.S_AXI_RVALID}, 32'h0);
    chk({tag, "_rdata"},   bus.S_AXI_RDATA, 32'h0);
    chk({tag, "_pulse"},   {28'h0, reg_wr_pulse}, 32'h0);
    chk({tag, "_regs_or"}, slv_reg0 | slv_reg1 | slv_reg2 | slv_reg3, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    bus.S_AXI_AWADDR  = 4'h0; bus.S_AXI_AWPROT = 3'b000; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = 32'h0; bus.S_AXI_WSTRB = 4'h0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    bus.S_AXI_ARADDR  = 4'h0; bus.S_AXI_ARPROT = 3'b000; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;

    #1 rst = 1'b1;
    #2 chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Sequential writes then reads of all four words
    for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF);
    chk("t1_slv_reg0", slv_reg0, 32'h1);
    chk("t1_slv_reg1", slv_reg1, 32'h2);
    chk("t1_slv_reg2", slv_reg2, 32'h3);
    chk("t1_slv_reg3", slv_reg3, 32'h4);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(4 * i), rd);
      chk($sformatf("t1_read%0d", i), rd, 32'(i + 1));
    end

    // W three cycles ahead of AW
    bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    @(negedge clk) chk("t2_wready_pre", {31'h0, bus.S_AXI_WREADY}, 32'h1);
    @(posedge clk); #1 bus.S_AXI_WVALID = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_wready_held", {31'h0, bus.S_AXI_WREADY}, 32'h0);
      chk("t2_bvalid_wait", {31'h0, bus.S_AXI_BVALID}, 32'h0);
      @(posedge clk); #1;
    end
    bus.S_AXI_AWADDR = 4'h8; bus.S_AXI_AWVALID = 1'b1;
    @(negedge clk) chk("t2_awready", {31'h0, bus.S_AXI_AWREADY}, 32'h1);
    @(posedge clk); #1 bus.S_AXI_AWVALID = 1'b0;
    @(negedge clk);
    chk("t2_bvalid", {31'h0, bus.S_AXI_BVALID}, 32'h1);
    chk("t2_pulse", {28'h0, reg_wr_pulse}, 32'h4);
    chk("t2_slv_reg2", slv_reg2, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(negedge clk) chk("t2_pulse_gone", {28'h0, reg_wr_pulse}, 32'h0);
    @(posedge clk); #1;

    // Byte-strobed update and an unaligned read of the same word
    axi_write(4'h4, 32'h11223344, 4'hF);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0010);
    chk("t3_slv_reg1", slv_reg1, 32'h1122CC44);
    axi_read(4'h6, rd);
    chk("t3_unaligned_read", rd, 32'h1122CC44);

    // Response back-pressure blocks the next write
    bus.S_AXI_BREADY = 1'b0;
    axi_write(4'hC, 32'h00000077, 4'hF);
    bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA  = 32'h00000088; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_bvalid_hold", {31'h0, bus.S_AXI_BVALID}, 32'h1);
      chk("t4_awready_low", {31'h0, bus.S_AXI_AWREADY}, 32'h0);
      chk("t4_wready_low", {31'h0, bus.S_AXI_WREADY}, 32'h0);
      @(posedge clk); #1;
    end
    chk("t4_slv_reg3_first", slv_reg3, 32'h77);
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk) chk("t4_awready_still_low", {31'h0, bus.S_AXI_AWREADY}, 32'h0);
    @(posedge clk); #1;
    axi_write(4'hC, 32'h00000088, 4'hF);
    chk("t4_slv_reg3_second", slv_reg3, 32'h88);

    // Read captured on the same edge as a write commit to the same word
    bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA  = 32'h55; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 4'h0; bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    chk("t5_ready_all", {29'h0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'h7);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    chk("t5_rvalid", {31'h0, bus.S_AXI_RVALID}, 32'h1);
    chk("t5_rdata_old", bus.S_AXI_RDATA, 32'h1);
    chk("t5_slv_reg0", slv_reg0, 32'h55);
    chk("t5_bvalid", {31'h0, bus.S_AXI_BVALID}, 32'h1);
    @(posedge clk); #1;
    axi_read(4'h0, rd);
    chk("t5_rdata_new", rd, 32'h55);

    // Reset between the AW and W halves of a write
    bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 bus.S_AXI_AWVALID = 1'b0;
    #2 rst = 1'b1;
    #1 chk_all_zero("t6_async");
    @(posedge clk); #1 rst = 1'b0;
    axi_write(4'h8, 32'h99, 4'hF);
    chk("t6_slv_reg2", slv_reg2, 32'h99);
    chk("t6_slv_reg1", slv_reg1, 32'h0);
    chk("t6_slv_reg0", slv_reg0, 32'h0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
endmodule
